// File: rtl/friscv_dbus_axil_bridge_if.sv
// Native data-memory port plus AXI4-lite master channels of the dbus bridge.
// The bridge uses the master modport; the memory side/slave uses the slave modport.
interface friscv_dbus_axil_bridge_if #(
    parameter int unsigned ADDRW = 16,
    parameter int unsigned XLEN  = 32
);
    // Native load/store port
    logic                mem_en;
    logic                mem_wr;
    logic [ADDRW-1:0]    mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_strb;
    logic [XLEN-1:0]     mem_rdata;
    logic                mem_ready;
    logic                mem_err;

    // AXI4-lite write channels
    logic                awvalid;
    logic                awready;
    logic [ADDRW+1:0]    awaddr;
    logic [2:0]          awprot;
    logic                wvalid;
    logic                wready;
    logic [XLEN-1:0]     wdata;
    logic [XLEN/8-1:0]   wstrb;
    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;

    // AXI4-lite read channels
    logic                arvalid;
    logic                arready;
    logic [ADDRW+1:0]    araddr;
    logic [2:0]          arprot;
    logic                rvalid;
    logic                rready;
    logic [XLEN-1:0]     rdata;
    logic [1:0]          rresp;

    modport master (
        input  mem_en, mem_wr, mem_addr, mem_wdata, mem_strb,
        output mem_rdata, mem_ready, mem_err,
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp,
        output arvalid, araddr, arprot, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        output mem_en, mem_wr, mem_addr, mem_wdata, mem_strb,
        input  mem_rdata, mem_ready, mem_err,
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output awready, wready, bvalid, bresp,
        input  arvalid, araddr, arprot, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/friscv_dbus_axil_bridge.sv
// Bridges the rv32i core's native data-memory port to a single-outstanding AXI4-lite master.
// Completion is a one-cycle mem_ready pulse with mem_err flagging a non-OKAY response.
module friscv_dbus_axil_bridge #(
    parameter int unsigned ADDRW = 16,
    parameter int unsigned XLEN  = 32
) (
    input logic                       aclk,
    input logic                       aresetn,
    friscv_dbus_axil_bridge_if.master bus
);

    localparam int unsigned STRBW = XLEN / 8;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StDone
    } state_e;

    state_e             state_q;
    logic [ADDRW+1:0]   addr_q;
    logic [XLEN-1:0]    wdata_q;
    logic [STRBW-1:0]   strb_q;
    logic               aw_done_q;
    logic               w_done_q;

    logic               aw_fire;
    logic               w_fire;
    logic               aw_ok;
    logic               w_ok;

    assign aw_fire = bus.awvalid & bus.awready;
    assign w_fire  = bus.wvalid & bus.wready;
    // A channel counts as done if it completed earlier or is handshaking this cycle.
    assign aw_ok   = aw_done_q | aw_fire;
    assign w_ok    = w_done_q | w_fire;

    // One captured address serves both channels; only one transaction is ever live.
    assign bus.awaddr = addr_q;
    assign bus.araddr = addr_q;
    assign bus.wdata  = wdata_q;
    assign bus.wstrb  = strb_q;
    assign bus.awprot = 3'b000;
    assign bus.arprot = 3'b000;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            wdata_q       <= '0;
            strb_q        <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            bus.awvalid   <= 1'b0;
            bus.wvalid    <= 1'b0;
            bus.bready    <= 1'b0;
            bus.arvalid   <= 1'b0;
            bus.rready    <= 1'b0;
            bus.mem_ready <= 1'b0;
            bus.mem_err   <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            bus.mem_ready <= 1'b0;
            bus.mem_err   <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (bus.mem_en) begin
                        addr_q  <= {bus.mem_addr, 2'b00};
                        wdata_q <= bus.mem_wdata;
                        strb_q  <= bus.mem_strb;
                        if (bus.mem_wr) begin
                            aw_done_q   <= 1'b0;
                            w_done_q    <= 1'b0;
                            bus.awvalid <= 1'b1;
                            bus.wvalid  <= 1'b1;
                            state_q     <= StWrReq;
                        end else begin
                            bus.arvalid <= 1'b1;
                            state_q     <= StRdReq;
                        end
                    end
                end

                StWrReq: begin
                    if (aw_fire) begin
                        bus.awvalid <= 1'b0;
                        aw_done_q   <= 1'b1;
                    end
                    if (w_fire) begin
                        bus.wvalid <= 1'b0;
                        w_done_q   <= 1'b1;
                    end
                    if (aw_ok && w_ok) begin
                        bus.bready <= 1'b1;
                        state_q    <= StWrResp;
                    end
                end

                StWrResp: begin
                    if (bus.bvalid) begin
                        bus.bready    <= 1'b0;
                        bus.mem_ready <= 1'b1;
                        bus.mem_err   <= (bus.bresp != 2'b00);
                        state_q       <= StDone;
                    end
                end

                StRdReq: begin
                    if (bus.arready) begin
                        bus.arvalid <= 1'b0;
                        bus.rready  <= 1'b1;
                        state_q     <= StRdResp;
                    end
                end

                StRdResp: begin
                    if (bus.rvalid) begin
                        bus.rready    <= 1'b0;
                        bus.mem_rdata <= bus.rdata;
                        bus.mem_ready <= 1'b1;
                        bus.mem_err   <= (bus.rresp != 2'b00);
                        state_q       <= StDone;
                    end
                end

                // The core changes its request on this edge, so mem_en is not looked at here.
                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_friscv_dbus_axil_bridge.sv
// Directed bench for friscv_dbus_axil_bridge: each task drives one scenario cycle by cycle
// and compares outputs against hand-computed values one time unit after the clock edge.
module tb_friscv_dbus_axil_bridge;

    logic aclk;
    logic aresetn;
    int   checks;
    int   failures;

    friscv_dbus_axil_bridge_if #(.ADDRW(16), .XLEN(32)) bus ();

    friscv_dbus_axil_bridge #(.ADDRW(16), .XLEN(32)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_strb  = '0;
        bus.awready   = 1'b0;
        bus.wready    = 1'b0;
        bus.bvalid    = 1'b0;
        bus.bresp     = 2'b00;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        bus.rdata     = '0;
        bus.rresp     = 2'b00;
    endtask

    task automatic test_reset();
        logic [110:0] outs;
        aresetn = 1'b0;
        idle_inputs();
        tick();
        tick();
        outs = {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.mem_ready,
                bus.mem_err, bus.mem_rdata, bus.awaddr, bus.araddr, bus.wdata, bus.wstrb};
        checks++;
        if (outs !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        checks++;
        if ({bus.awprot, bus.arprot} !== 6'b0) begin
            failures++; $display("FAIL prot got=%b exp=000000", {bus.awprot, bus.arprot});
        end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_write_zero_wait();
        bus.mem_en = 1'b1; bus.mem_wr = 1'b1; bus.mem_addr = 16'h0010;
        bus.mem_wdata = 32'hDEADBEEF; bus.mem_strb = 4'b1111;
        bus.awready = 1'b1; bus.wready = 1'b1;
        tick();  // cycle 1
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.mem_ready} !== 4'b1100) begin
            failures++; $display("FAIL wr0_c1_valids got=%b exp=1100",
                                 {bus.awvalid, bus.wvalid, bus.arvalid, bus.mem_ready});
        end
        checks++;
        if ({bus.awaddr, bus.wdata, bus.wstrb} !== {18'h00040, 32'hDEADBEEF, 4'hF}) begin
            failures++; $display("FAIL wr0_c1_payload got=%h exp=%h",
                                 {bus.awaddr, bus.wdata, bus.wstrb},
                                 {18'h00040, 32'hDEADBEEF, 4'hF});
        end
        bus.bvalid = 1'b1; bus.bresp = 2'b00;
        tick();  // cycle 2
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.bready, bus.mem_ready} !== 4'b0010) begin
            failures++; $display("FAIL wr0_c2 got=%b exp=0010",
                                 {bus.awvalid, bus.wvalid, bus.bready, bus.mem_ready});
        end
        tick();  // cycle 3
        checks++;
        if ({bus.mem_ready, bus.mem_err, bus.bready} !== 3'b100) begin
            failures++; $display("FAIL wr0_c3_done got=%b exp=100",
                                 {bus.mem_ready, bus.mem_err, bus.bready});
        end
        idle_inputs();
        tick();  // cycle 4
        checks++;
        if (bus.mem_ready !== 1'b0) begin
            failures++; $display("FAIL wr0_c4_pulse got=%b exp=0", bus.mem_ready);
        end
    endtask

    task automatic test_read_delay();
        bus.mem_en = 1'b1; bus.mem_wr = 1'b0; bus.mem_addr = 16'h1234; bus.arready = 1'b1;
        tick();  // cycle 1
        checks++;
        if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.araddr} !== {3'b100, 18'h048D0}) begin
            failures++; $display("FAIL rd_c1 got=%h exp=%h",
                                 {bus.arvalid, bus.awvalid, bus.wvalid, bus.araddr},
                                 {3'b100, 18'h048D0});
        end
        tick();  // cycle 2
        for (int i = 2; i < 6; i++) begin
            checks++;
            if ({bus.arvalid, bus.rready, bus.mem_ready} !== 3'b010) begin
                failures++; $display("FAIL rd_wait_c%0d got=%b exp=010", i,
                                     {bus.arvalid, bus.rready, bus.mem_ready});
            end
            tick();
        end
        checks++;
        if (bus.rready !== 1'b1) begin
            failures++; $display("FAIL rd_c6_rready got=%b exp=1", bus.rready);
        end
        bus.rvalid = 1'b1; bus.rdata = 32'h12345678; bus.rresp = 2'b00;
        tick();  // cycle 7
        checks++;
        if ({bus.mem_ready, bus.mem_err, bus.rready, bus.mem_rdata} !== {3'b100, 32'h12345678})
        begin
            failures++; $display("FAIL rd_c7_done got=%h exp=%h",
                                 {bus.mem_ready, bus.mem_err, bus.rready, bus.mem_rdata},
                                 {3'b100, 32'h12345678});
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.mem_ready, bus.mem_rdata} !== {1'b0, 32'h12345678}) begin
                failures++; $display("FAIL rd_hold_%0d got=%h exp=%h", i,
                                     {bus.mem_ready, bus.mem_rdata}, {1'b0, 32'h12345678});
            end
        end
    endtask

    task automatic test_write_w_first();
        bus.mem_en = 1'b1; bus.mem_wr = 1'b1; bus.mem_addr = 16'h0020;
        bus.mem_wdata = 32'hA5A55A5A; bus.mem_strb = 4'b0011;
        bus.awready = 1'b0; bus.wready = 1'b1;
        tick();  // cycle 1
        checks++;
        if ({bus.awvalid, bus.wvalid} !== 2'b11) begin
            failures++; $display("FAIL wf_c1 got=%b exp=11", {bus.awvalid, bus.wvalid});
        end
        tick();  // cycle 2
        bus.wready = 1'b0;
        for (int i = 2; i < 4; i++) begin
            checks++;
            if ({bus.awvalid, bus.wvalid, bus.bready, bus.awaddr} !== {3'b100, 18'h00080}) begin
                failures++; $display("FAIL wf_c%0d got=%h exp=%h", i,
                                     {bus.awvalid, bus.wvalid, bus.bready, bus.awaddr},
                                     {3'b100, 18'h00080});
            end
            if (i == 2) tick();
        end
        bus.awready = 1'b1;
        tick();  // cycle 4
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) begin
            failures++; $display("FAIL wf_c4 got=%b exp=001",
                                 {bus.awvalid, bus.wvalid, bus.bready});
        end
        bus.awready = 1'b0; bus.bvalid = 1'b1;
        tick();  // cycle 5
        checks++;
        if ({bus.mem_ready, bus.mem_err, bus.mem_rdata} !== {2'b10, 32'h12345678}) begin
            failures++; $display("FAIL wf_c5_done got=%h exp=%h",
                                 {bus.mem_ready, bus.mem_err, bus.mem_rdata},
                                 {2'b10, 32'h12345678});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        bus.mem_en = 1'b1; bus.mem_wr = 1'b1; bus.mem_addr = 16'h0003;
        bus.mem_wdata = 32'h11223300; bus.mem_strb = 4'b1110;
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1;
        tick();  // cycle 1
        checks++;
        if ({bus.awvalid, bus.awaddr, bus.wstrb} !== {1'b1, 18'h0000C, 4'b1110}) begin
            failures++; $display("FAIL b2b_first got=%h exp=%h",
                                 {bus.awvalid, bus.awaddr, bus.wstrb},
                                 {1'b1, 18'h0000C, 4'b1110});
        end
        tick();  // cycle 2
        tick();  // cycle 3
        if (bus.mem_ready === 1'b1) pulses++;
        bus.mem_addr = 16'h0004; bus.mem_wdata = 32'h00000044; bus.mem_strb = 4'b0001;
        tick();  // cycle 4: request must not have been taken during DONE
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.mem_ready} !== 3'b000) begin
            failures++; $display("FAIL b2b_done_ignored got=%b exp=000",
                                 {bus.awvalid, bus.wvalid, bus.mem_ready});
        end
        tick();  // cycle 5
        checks++;
        if ({bus.awvalid, bus.awaddr, bus.wdata, bus.wstrb} !==
            {1'b1, 18'h00010, 32'h00000044, 4'b0001}) begin
            failures++; $display("FAIL b2b_second got=%h exp=%h",
                                 {bus.awvalid, bus.awaddr, bus.wdata, bus.wstrb},
                                 {1'b1, 18'h00010, 32'h00000044, 4'b0001});
        end
        tick();  // cycle 6
        if (bus.mem_ready === 1'b1) pulses++;
        tick();  // cycle 7
        if (bus.mem_ready === 1'b1) pulses++;
        idle_inputs();
        tick();
        checks++;
        if (pulses !== 2) begin
            failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses);
        end
    endtask

    task automatic test_error();
        bus.mem_en = 1'b1; bus.mem_wr = 1'b0; bus.mem_addr = 16'h0100; bus.arready = 1'b1;
        tick();  // cycle 1
        bus.rvalid = 1'b1; bus.rdata = 32'hCAFEF00D; bus.rresp = 2'b10;
        tick();  // cycle 2
        tick();  // cycle 3
        checks++;
        if ({bus.mem_ready, bus.mem_err, bus.mem_rdata} !== {2'b11, 32'hCAFEF00D}) begin
            failures++; $display("FAIL rerr_c3 got=%h exp=%h",
                                 {bus.mem_ready, bus.mem_err, bus.mem_rdata},
                                 {2'b11, 32'hCAFEF00D});
        end
        idle_inputs();
        tick();  // cycle 4
        checks++;
        if ({bus.mem_ready, bus.mem_err} !== 2'b00) begin
            failures++; $display("FAIL rerr_c4_clear got=%b exp=00", {bus.mem_ready, bus.mem_err});
        end
        bus.mem_en = 1'b1; bus.mem_wr = 1'b1; bus.mem_addr = 16'h0200;
        bus.mem_wdata = 32'h0; bus.mem_strb = 4'b0000;
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1; bus.bresp = 2'b11;
        tick();  // cycle 1
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.wstrb} !== 6'b110000) begin
            failures++; $display("FAIL werr_zero_strb got=%b exp=110000",
                                 {bus.awvalid, bus.wvalid, bus.wstrb});
        end
        tick();
        tick();  // cycle 3
        checks++;
        if ({bus.mem_ready, bus.mem_err, bus.mem_rdata} !== {2'b11, 32'hCAFEF00D}) begin
            failures++; $display("FAIL werr_c3 got=%h exp=%h",
                                 {bus.mem_ready, bus.mem_err, bus.mem_rdata},
                                 {2'b11, 32'hCAFEF00D});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [110:0] outs;
        bus.mem_en = 1'b1; bus.mem_wr = 1'b0; bus.mem_addr = 16'h0300; bus.arready = 1'b1;
        tick();  // cycle 1
        tick();  // cycle 2
        bus.arready = 1'b0;
        tick();  // cycle 3
        checks++;
        if (bus.rready !== 1'b1) begin
            failures++; $display("FAIL rstmid_rready got=%b exp=1", bus.rready);
        end
        aresetn = 1'b0;
        idle_inputs();
        tick();
        outs = {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.mem_ready,
                bus.mem_err, bus.mem_rdata, bus.awaddr, bus.araddr, bus.wdata, bus.wstrb};
        checks++;
        if (outs !== '0) begin
            failures++; $display("FAIL rstmid_outputs got=%h exp=0", outs);
        end
        aresetn = 1'b1;
        tick();
        bus.mem_en = 1'b1; bus.mem_wr = 1'b1; bus.mem_addr = 16'h0005;
        bus.mem_wdata = 32'h0BADF00D; bus.mem_strb = 4'b1111;
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1;
        tick();  // cycle 1
        checks++;
        if ({bus.awvalid, bus.awaddr, bus.wdata} !== {1'b1, 18'h00014, 32'h0BADF00D}) begin
            failures++; $display("FAIL rstmid_wr_c1 got=%h exp=%h",
                                 {bus.awvalid, bus.awaddr, bus.wdata},
                                 {1'b1, 18'h00014, 32'h0BADF00D});
        end
        tick();
        tick();  // cycle 3
        checks++;
        if ({bus.mem_ready, bus.mem_err, bus.mem_rdata} !== {2'b10, 32'h0}) begin
            failures++; $display("FAIL rstmid_wr_done got=%h exp=%h",
                                 {bus.mem_ready, bus.mem_err, bus.mem_rdata}, {2'b10, 32'h0});
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        aresetn  = 1'b0;
        idle_inputs();
        test_reset();
        test_write_zero_wait();
        test_read_delay();
        test_write_w_first();
        test_back_to_back();
        test_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/friscv_dbus_axil_bridge.md
Name: friscv_dbus_axil_bridge

Overview:
- Downstream neighbour of the load/store unit in the rv32i core.
- Converts the core's native data-memory port (mem_en/mem_wr/word address/strobes, acknowledged by a mem_ready pulse) into an AXI4-lite master.
- Handles one outstanding transaction at a time. Two-phase unaligned accesses therefore arrive as two back-to-back native requests.
- Also reports AXI error responses to the control unit.

Parameters:
- ADDRW, 16, native word-address width; AXI address width is ADDRW+2.
- XLEN, 32, data width; strobe width is XLEN/8.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- mem_en  in  1  native request valid; held high until mem_ready
- mem_wr  in  1  1=store, 0=load
- mem_addr  in  ADDRW  word address
- mem_wdata  in  XLEN  store data, pre-aligned
- mem_strb  in  XLEN/8  store byte enables
- mem_rdata  out  XLEN  load data, valid while mem_ready=1
- mem_ready  out  1  one-cycle completion pulse
- mem_err  out  1  high with mem_ready when the response is not OKAY
- awvalid  out  1  AXI write address valid
- awready  in  1  AXI write address ready
- awaddr  out  ADDRW+2  AXI write address
- awprot  out  3  AXI write protection
- wvalid  out  1  AXI write data valid
- wready  in  1  AXI write data ready
- wdata  out  XLEN  AXI write data
- wstrb  out  XLEN/8  AXI write strobes
- bvalid  in  1  AXI write response valid
- bready  out  1  AXI write response ready
- bresp  in  2  AXI write response code
- arvalid  out  1  AXI read address valid
- arready  in  1  AXI read address ready
- araddr  out  ADDRW+2  AXI read address
- arprot  out  3  AXI read protection
- rvalid  in  1  AXI read data valid
- rready  out  1  AXI read data ready
- rdata  in  XLEN  AXI read data
- rresp  in  2  AXI read response code

Behaviour:
- Reset (aresetn=0 at a rising edge): state=IDLE. All outputs 0: valids, bready, rready, mem_ready, mem_err, mem_rdata, addresses, wdata, wstrb.
- Reset mid-transaction: valids drop at that edge and the outstanding AXI transaction is abandoned. Slave reset is a system-level requirement.
- awprot and arprot are constant 3'b000.
- Address: awaddr/araddr = {mem_addr, 2'b00}, registered at request capture.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: if mem_en=1, register address, wdata and wstrb (mem_strb forwarded unmodified, including all-zero).
  - If mem_wr=1, go to WR_REQ with awvalid=wvalid=1.
  - Else go to RD_REQ with arvalid=1.
  - Transaction type is fixed at capture; later changes on mem_* are ignored until DONE.
- WR_REQ: awvalid and wvalid are independent.
  - Each drops at the edge where its own ready is high; aw_done/w_done flags record completion.
  - Addresses and data stay stable while valid is high; a valid never drops without its ready.
  - When both are done (same or different cycles), go to WR_RESP.
- WR_RESP: bready=1. On bvalid, set mem_err = (bresp!=2'b00) and go to DONE.
- RD_REQ: arvalid=1 until arready, then go to RD_RESP.
- RD_RESP: rready=1. On rvalid, register mem_rdata=rdata and mem_err=(rresp!=2'b00), then go to DONE.
- DONE: mem_ready=1 for exactly this cycle. The next state is always IDLE; mem_en is not sampled in DONE, because the core updates its request at this edge.
- mem_rdata holds its value until the next read completes. Writes leave mem_rdata unchanged.
- mem_err clears in the next cycle.
- Latency with zero-wait slave: mem_en sampled in cycle 0, AXI valid in cycle 1, response ready in cycle 2, mem_ready in cycle 3.
  - Minimum spacing between back-to-back native requests is 4 cycles.
- Never more than one AXI transaction outstanding. A read and a write are never simultaneously valid.

Test Plan:
- Write, zero-wait slave: mem_addr=0x0010, wdata=0xDEADBEEF, strb=4'b1111 → awaddr=0x00040; awvalid and wvalid in cycle 1; mem_ready in cycle 3 with mem_err=0.
- Read with 5-cycle rvalid delay, rdata=0x12345678 → rready held 5 cycles; mem_rdata=0x12345678 with mem_ready in cycle 7; value held afterwards.
- Write with wready 2 cycles before awready → wvalid drops first, awvalid held with stable awaddr; WR_RESP entered only after both handshakes.
- Two-phase unaligned store: word addresses 0x0003 then 0x0004, strb 4'b1110 then 4'b0001 → two AXI writes, two mem_ready pulses, no request sampled during DONE.
- Error response: rresp=2'b10 → mem_err=1 and mem_ready=1 in the same cycle; mem_err=0 in the next cycle.
- aresetn=0 during RD_RESP → next cycle rready=0, state=IDLE, all outputs 0; a new write after reset completes normally.
